// File: rtl/ins_memory_param.sv
// Instruction memory: sequential byte loader, IDLE/LOAD/RUN FSM, registered big-endian word fetch.
// Optional fetch-fault detection is enabled by defining IMEM_FAULT_EN.
module ins_memory_param #(
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [31:0]        NOP_WORD  = 32'h0000_0013,
  localparam int                IDX_W     = $clog2(DEPTH),
  localparam int                CNT_W     = IDX_W + 1
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              SYS_start_button,
  input  logic [ADDR_W-1:0] PC,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              execution_enable,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [CNT_W-1:0]  load_count,
  output logic              load_overflow,
  output logic              fault
);

  localparam int ROWS  = DEPTH / 4;
  localparam int ROW_W = (IDX_W > 2) ? IDX_W - 2 : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              instr_valid_q, instr_valid_d;
  logic              nop_q, nop_d;
  logic [1:0]        sel_q, sel_d;
  logic              fault_q, fault_d;

  logic              accept;
  logic              fetch_en;
  logic              fetch_fault;
  logic [ADDR_W-1:0] pc_off;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        byte_loaded;
  logic [7:0]        rdata [4];

  assign load_ready = (state_q != ST_RUN) && (count_q < CNT_W'(DEPTH));
  assign accept     = load_valid && load_ready;
  assign fetch_en   = (state_q == ST_RUN);
  assign pc_off     = PC - BASE_ADDR;
  assign idx        = pc_off[IDX_W-1:0];

`ifdef IMEM_FAULT_EN
  assign fetch_fault = (PC[1:0] != 2'b00) || (pc_off > ADDR_W'(DEPTH - 4));
`else
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_off;
  assign fetch_fault    = 1'b0;
`endif

  // Storage is split into four byte banks by address[1:0] so each bank is a
  // single-port-read array; unaligned fetches pick the right row per bank.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0]       bank [ROWS];
      logic [7:0]       rdata_q;
      logic [1:0]       roff;
      logic [IDX_W-1:0] raddr;
      logic [ROW_W-1:0] rrow;
      logic [ROW_W-1:0] wrow;
      logic             we;
      logic [IDX_W-1:0] chk_addr;

      assign roff     = 2'(gi) - idx[1:0];
      assign raddr    = idx + IDX_W'(roff);
      assign rrow     = ROW_W'(raddr >> 2);
      assign wrow     = ROW_W'(count_q[IDX_W-1:0] >> 2);
      assign we       = accept && (count_q[1:0] == 2'(gi));

      always_ff @(posedge SYS_clk) begin
        if (we) begin
          bank[wrow] <= load_data;
        end
        if (fetch_en) begin
          rdata_q <= bank[rrow];
        end
      end

      assign rdata[gi] = rdata_q;

      // Loaded bytes always occupy indices 0..count-1, so a byte is valid iff below the count.
      assign chk_addr        = idx + IDX_W'(gi);
      assign byte_loaded[gi] = ({1'b0, chk_addr} < count_q);
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    instr_valid_d = 1'b0;
    nop_d         = nop_q;
    sel_d         = sel_q;
    fault_d       = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (SYS_start_button) begin
          state_d = ST_RUN;
        end else if (accept) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (SYS_start_button) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (accept) begin
      count_d = count_q + 1'b1;
    end
    if (load_valid && (state_q != ST_RUN) && !load_ready) begin
      overflow_d = 1'b1;
    end

    if (fetch_en) begin
      instr_valid_d = 1'b1;
      sel_d         = idx[1:0];
      nop_d         = !(&byte_loaded) || fetch_fault;
      fault_d       = fetch_fault;
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      nop_q         <= 1'b1;
      sel_q         <= 2'b00;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      instr_valid_q <= instr_valid_d;
      nop_q         <= nop_d;
      sel_q         <= sel_d;
      fault_q       <= fault_d;
    end
  end

  // Byte k of the word comes from bank (sel + k) mod 4; NOP overrides when any byte is unloaded.
  logic [1:0] bsel0, bsel1, bsel2, bsel3;
  assign bsel0 = sel_q;
  assign bsel1 = sel_q + 2'd1;
  assign bsel2 = sel_q + 2'd2;
  assign bsel3 = sel_q + 2'd3;

  assign instruction      = nop_q ? NOP_WORD
                                  : {rdata[bsel0], rdata[bsel1], rdata[bsel2], rdata[bsel3]};
  assign execution_enable = (state_q == ST_RUN);
  assign instr_valid      = instr_valid_q;
  assign load_count       = count_q;
  assign load_overflow    = overflow_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_ins_memory_param.sv
// Directed bench for ins_memory_param (DEPTH=16, BASE_ADDR=0x100); fault checks follow IMEM_FAULT_EN.
module tb_ins_memory_param;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        lv;
  logic [7:0]  ld;
  logic        lrdy;
  logic        exe;
  logic [31:0] instr;
  logic        ivalid;
  logic [4:0]  lcnt;
  logic        ovf;
  logic        flt;

  int checks   = 0;
  int failures = 0;

  ins_memory_param #(
    .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_WORD(NOP)
  ) dut (
    .SYS_clk(clk), .SYS_reset(rst), .SYS_start_button(start), .PC(pc),
    .load_valid(lv), .load_data(ld), .load_ready(lrdy), .execution_enable(exe),
    .instruction(instr), .instr_valid(ivalid), .load_count(lcnt),
    .load_overflow(ovf), .fault(flt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; lv = 1'b0; ld = 8'h00; pc = BASE;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    lv = 1'b1; ld = b;
    step();
    lv = 1'b0;
    $display("load byte=%h count=%0d ready=%b ovf=%b", b, lcnt, lrdy, ovf);
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    pc = addr;
    step();
    $display("fetch pc=%h instr=%h valid=%b fault=%b", addr, instr, ivalid, flt);
  endtask

  task automatic load_prog8();
    logic [7:0] prog [8];
    prog = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 8; i++) load_byte(prog[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; lv = 1'b0; ld = 8'h00; pc = BASE;
    #1;
    checks++; if (exe !== 1'b0)   begin failures++; $display("FAIL reset_exe got=%b exp=0", exe); end
    checks++; if (instr !== NOP)  begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    checks++; if (ivalid !== 1'b0) begin failures++; $display("FAIL reset_ivalid got=%b exp=0", ivalid); end
    checks++; if (lcnt !== 5'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", lcnt); end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (flt !== 1'b0)   begin failures++; $display("FAIL reset_fault got=%b exp=0", flt); end
    checks++; if (lrdy !== 1'b1)  begin failures++; $display("FAIL reset_ready got=%b exp=1", lrdy); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    load_prog8();
    checks++; if (lcnt !== 5'd8) begin failures++; $display("FAIL basic_count got=%0d exp=8", lcnt); end
    checks++; if (exe !== 1'b0)  begin failures++; $display("FAIL basic_exe_pre got=%b exp=0", exe); end
    press_start();
    checks++; if (exe !== 1'b1)  begin failures++; $display("FAIL basic_exe got=%b exp=1", exe); end
    checks++; if (lrdy !== 1'b0) begin failures++; $display("FAIL basic_ready_run got=%b exp=0", lrdy); end
    fetch(BASE);
    checks++; if (instr !== 32'h1305_1000) begin failures++; $display("FAIL basic_word0 got=%h exp=13051000", instr); end
    checks++; if (ivalid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", ivalid); end
    fetch(BASE + 32'd4);
    checks++; if (instr !== 32'h9305_2000) begin failures++; $display("FAIL basic_word1 got=%h exp=93052000", instr); end
    // Start re-pressed in RUN changes nothing.
    start = 1'b1;
    fetch(BASE);
    start = 1'b0;
    checks++; if (instr !== 32'h1305_1000 || exe !== 1'b1) begin failures++; $display("FAIL basic_restart got=%h/%b exp=13051000/1", instr, exe); end
  endtask

  task automatic test_unloaded();
    do_reset();
    load_byte(8'h13); load_byte(8'h05); load_byte(8'h10); load_byte(8'h00);
    press_start();
    fetch(BASE + 32'd4);
    checks++; if (instr !== NOP) begin failures++; $display("FAIL unloaded_full got=%h exp=%h", instr, NOP); end
    fetch(BASE + 32'd2);
    checks++; if (instr !== NOP) begin failures++; $display("FAIL unloaded_part got=%h exp=%h", instr, NOP); end
    fetch(BASE);
    checks++; if (instr !== 32'h1305_1000) begin failures++; $display("FAIL unloaded_word0 got=%h exp=13051000", instr); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 15; i++) load_byte(8'h40 + 8'(i));
    checks++; if (lrdy !== 1'b1) begin failures++; $display("FAIL ovf_ready15 got=%b exp=1", lrdy); end
    load_byte(8'h4F);
    checks++; if (lrdy !== 1'b0) begin failures++; $display("FAIL ovf_ready16 got=%b exp=0", lrdy); end
    checks++; if (ovf !== 1'b0)  begin failures++; $display("FAIL ovf_early got=%b exp=0", ovf); end
    load_byte(8'hEE);
    checks++; if (ovf !== 1'b1)  begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    checks++; if (lcnt !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", lcnt); end
    press_start();
    fetch(BASE + 32'd12);
    checks++; if (instr !== 32'h4C4D_4E4F) begin failures++; $display("FAIL ovf_last_word got=%h exp=4c4d4e4f", instr); end
`ifndef IMEM_FAULT_EN
    fetch(BASE + 32'd14);
    checks++; if (instr !== 32'h4E4F_4041) begin failures++; $display("FAIL wrap_word got=%h exp=4e4f4041", instr); end
    fetch(BASE + 32'd5);
    checks++; if (instr !== 32'h4546_4748) begin failures++; $display("FAIL unaligned_word got=%h exp=45464748", instr); end
`endif
  endtask

  task automatic test_start_with_byte();
    do_reset();
    load_byte(8'h01); load_byte(8'h02); load_byte(8'h03);
    lv = 1'b1; ld = 8'hAA; start = 1'b1;
    step();
    lv = 1'b0; start = 1'b0;
    checks++; if (exe !== 1'b1)  begin failures++; $display("FAIL same_edge_exe got=%b exp=1", exe); end
    checks++; if (lcnt !== 5'd4) begin failures++; $display("FAIL same_edge_count got=%0d exp=4", lcnt); end
    load_byte(8'h55);
    checks++; if (lcnt !== 5'd4 || ovf !== 1'b0) begin failures++; $display("FAIL run_load_ignored got=%0d/%b exp=4/0", lcnt, ovf); end
    fetch(BASE);
    checks++; if (instr !== 32'h0102_03AA) begin failures++; $display("FAIL same_edge_word got=%h exp=010203aa", instr); end
  endtask

  task automatic test_fault();
    do_reset();
    load_prog8();
    press_start();
`ifdef IMEM_FAULT_EN
    fetch(BASE + 32'd1);
    checks++; if (flt !== 1'b1 || instr !== NOP || ivalid !== 1'b1) begin failures++; $display("FAIL fault_misalign got=%b/%h/%b exp=1/%h/1", flt, instr, ivalid, NOP); end
    fetch(BASE + 32'(DEPTH));
    checks++; if (flt !== 1'b1 || instr !== NOP) begin failures++; $display("FAIL fault_range got=%b/%h exp=1/%h", flt, instr, NOP); end
    fetch(BASE - 32'd4);
    checks++; if (flt !== 1'b1) begin failures++; $display("FAIL fault_below got=%b exp=1", flt); end
    fetch(BASE);
    checks++; if (flt !== 1'b0 || instr !== 32'h1305_1000) begin failures++; $display("FAIL fault_clear got=%b/%h exp=0/13051000", flt, instr); end
`else
    fetch(BASE + 32'(DEPTH));
    checks++; if (flt !== 1'b0 || instr !== 32'h1305_1000) begin failures++; $display("FAIL modulo_wrap got=%b/%h exp=0/13051000", flt, instr); end
    fetch(BASE + 32'd1);
    checks++; if (flt !== 1'b0 || instr !== 32'h0510_0093) begin failures++; $display("FAIL modulo_misalign got=%b/%h exp=0/05100093", flt, instr); end
`endif
  endtask

  task automatic test_async_reset();
    fetch(BASE + 32'd4);
    checks++; if (lcnt !== 5'd8 || ivalid !== 1'b1) begin failures++; $display("FAIL pre_reset got=%0d/%b exp=8/1", lcnt, ivalid); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (exe !== 1'b0)    begin failures++; $display("FAIL async_exe got=%b exp=0", exe); end
    checks++; if (ivalid !== 1'b0) begin failures++; $display("FAIL async_ivalid got=%b exp=0", ivalid); end
    checks++; if (lcnt !== 5'd0)   begin failures++; $display("FAIL async_count got=%0d exp=0", lcnt); end
    checks++; if (instr !== NOP)   begin failures++; $display("FAIL async_instr got=%h exp=%h", instr, NOP); end
    #2 rst = 1'b0;
    fetch(BASE);
    checks++; if (exe !== 1'b0 || ivalid !== 1'b0 || instr !== NOP) begin failures++; $display("FAIL post_reset got=%b/%b/%h exp=0/0/%h", exe, ivalid, instr, NOP); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_unloaded();
    test_overflow();
    test_start_with_byte();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
